// File: rtl/guvm_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package guvm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_IC = 1'b0,
    SIDE_DC = 1'b1
  } side_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic HOLD_STALL = 1'b0;

  // Byte accesses and the unused 2'b11 encoding never fault on alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
           ((size == SZ_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/guvm_mem_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the memory model (slave).
interface guvm_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ack, mem_rdata, mem_err
  );

endinterface

// File: rtl/guvm_mem_arbiter_rr.sv
// Two-way round-robin grant; the pointer only moves when both sides compete.
module guvm_rr_arb2
  import guvm_mem_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  req_ic,
  input  logic  req_dc,
  output logic  gnt_valid,
  output side_e gnt_side
);

  side_e ptr;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt_valid = en && (req_ic || req_dc);
    gnt_side  = SIDE_IC;
    if (req_ic && req_dc) gnt_side = ptr;
    else if (req_dc)      gnt_side = SIDE_DC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= side_e'(DATA_FIRST);
    end else if (en && req_ic && req_dc) begin
      ptr <= (ptr == SIDE_IC) ? SIDE_DC : SIDE_IC;
    end
  end

endmodule

// File: rtl/guvm_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one outstanding transaction at a time, with a one-cycle response.
module guvm_mem_arbiter
  import guvm_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_hold,
  output logic [DATA_W-1:0] ic_data,
  output logic              ic_mexc,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [1:0]        dc_size,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_hold,
  output logic [DATA_W-1:0] dc_data,
  output logic              dc_mexc,
  output logic              dc_werr,
  guvm_mem_arbiter_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e            state;
  side_e             side;
  logic              mem_req_q;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;

  logic              gnt_valid;
  side_e             gnt_side;
  logic              timeout_hit;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  guvm_rr_arb2 #(.DATA_FIRST(DATA_FIRST)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (state == IDLE),
    .req_ic    (ic_req),
    .req_dc    (dc_req),
    .gnt_valid (gnt_valid),
    .gnt_side  (gnt_side)
  );

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // A timeout completes like an error ack with zero data; a real ack in the same cycle wins.
  assign resp_data = mem.mem_ack ? mem.mem_rdata : '0;
  assign resp_err  = mem.mem_ack ? mem.mem_err   : 1'b1;

  assign ic_hold = (!rst || (ic_req && !(state == DONE && side == SIDE_IC))) ? HOLD_STALL : ~HOLD_STALL;
  assign dc_hold = (!rst || (dc_req && !(state == DONE && side == SIDE_DC))) ? HOLD_STALL : ~HOLD_STALL;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = lat_we;
  assign mem.mem_size  = lat_size;
  assign mem.mem_addr  = lat_addr;
  assign mem.mem_wdata = lat_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      side      <= SIDE_IC;
      mem_req_q <= 1'b0;
      lat_we    <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      ic_data   <= '0;
      ic_mexc   <= 1'b0;
      dc_data   <= '0;
      dc_mexc   <= 1'b0;
      dc_werr   <= 1'b0;
    end else begin
      // Response fields are live only during the DONE cycle.
      ic_data <= '0;
      ic_mexc <= 1'b0;
      dc_data <= '0;
      dc_mexc <= 1'b0;
      dc_werr <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            side <= gnt_side;
            cnt  <= '0;
            if (gnt_side == SIDE_DC) begin
              lat_we    <= dc_we;
              lat_size  <= dc_size;
              lat_addr  <= dc_addr;
              lat_wdata <= dc_wdata;
            end else begin
              lat_we    <= 1'b0;
              lat_size  <= SZ_WORD;
              lat_addr  <= ic_addr;
              lat_wdata <= '0;
            end
            if (gnt_side == SIDE_DC && misaligned(dc_size, dc_addr[1:0])) begin
              state   <= DONE;
              dc_mexc <= !dc_we;
              dc_werr <= dc_we;
            end else begin
              state     <= MEM;
              mem_req_q <= 1'b1;
            end
          end
        end

        MEM: begin
          if (mem.mem_ack || timeout_hit) begin
            state     <= DONE;
            mem_req_q <= 1'b0;
            // A requester that has gone away gets nothing, not even the error.
            if (side == SIDE_IC) begin
              if (ic_req) begin
                ic_data <= resp_data;
                ic_mexc <= resp_err;
              end
            end else if (dc_req) begin
              dc_data <= lat_we ? '0 : resp_data;
              dc_mexc <= !lat_we && resp_err;
              dc_werr <= lat_we && resp_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
